pwm_capture: RTL and testbench

- Receive-side counterpart of the team's free-running 8-bit PWM generator. It measures an incoming PWM waveform and reports the high time and period in clk cycles.
- Sits on the sense path, for loopback checking of generator outputs or for decoding an external PWM command line.
- Reports a one-cycle result strobe per completed period, and flags a stuck-high or stuck-low line.

---
 rtl/pwm_capture.sv | 188 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clk cycles, flags stuck lines.
// Optional glitch filter on the synchronized level is enabled by defining PWM_CAPTURE_FILTER_EN.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int CNT_W       = 8,
  parameter int PER_W       = CNT_W + 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 384,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [PER_W-1:0] high_time,
  output logic [PER_W-1:0] period,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [PER_W-1:0] CNT_MAX = '1;
  localparam logic [PER_W-1:0] TO_LAST = PER_W'(TIMEOUT - 1);

  if (SYNC_STAGES < 2 || TIMEOUT <= 2**CNT_W || TIMEOUT > 2**PER_W - 1 || FILTER_LEN < 1)
  begin : g_bad_cfg
    $error("pwm_capture: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_q, lvl_d;
  logic                   lvl_dly_q;
  logic [PER_W-1:0]       period_cnt_q, period_cnt_d;
  logic [PER_W-1:0]       high_cnt_q, high_cnt_d;
  logic [PER_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [PER_W-1:0]       high_time_q, high_time_d;
  logic [PER_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   stuck_hi_q, stuck_hi_d;
  logic                   stuck_lo_q, stuck_lo_d;
  logic                   sync_out;
  logic                   rise;
  logic                   fall;

  function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0] filt_cnt_q, filt_cnt_d;

  // Level follows the synchronizer only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    lvl_d      = lvl_q;
    filt_cnt_d = '0;
    if (sync_out != lvl_q) begin
      if (filt_cnt_q == FILT_LAST) lvl_d = sync_out;
      else                         filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) filt_cnt_q <= '0;
    else       filt_cnt_q <= filt_cnt_d;
  end
`else
  assign lvl_d = sync_out;
`endif

  assign rise = lvl_q & ~lvl_dly_q;
  assign fall = ~lvl_q & lvl_dly_q;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_hi_d   = stuck_hi_q;
    stuck_lo_d   = stuck_lo_q;
    case (state_q)
      IDLE: begin
        state_d      = ARM;
        period_cnt_d = '0;
        high_cnt_d   = '0;
        idle_cnt_d   = '0;
        stuck_hi_d   = 1'b0;
        stuck_lo_d   = 1'b0;
      end
      ARM, MEAS: begin
        if (rise) begin
          // The first rise after arming only opens a period; it never reports.
          if (state_q == MEAS) begin
            period_d    = period_cnt_q;
            high_time_d = high_cnt_q;
            valid_d     = 1'b1;
          end
          period_cnt_d = PER_W'(1);
          high_cnt_d   = PER_W'(1);
          idle_cnt_d   = '0;
          stuck_hi_d   = 1'b0;
          stuck_lo_d   = 1'b0;
          state_d      = MEAS;
        end else begin
          if (state_q == MEAS) begin
            period_cnt_d = sat_inc(period_cnt_q);
            if (lvl_q) high_cnt_d = sat_inc(high_cnt_q);
          end
          if (fall) begin
            idle_cnt_d = '0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
          end else if (idle_cnt_q == TO_LAST) begin
            // Restarting the idle count just re-asserts the same flag if the line stays put.
            idle_cnt_d   = '0;
            stuck_hi_d   = lvl_q;
            stuck_lo_d   = ~lvl_q;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            state_d      = ARM;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      idle_cnt_d   = '0;
      high_time_d  = high_time_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      stuck_hi_d   = 1'b0;
      stuck_lo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      lvl_q        <= 1'b0;
      lvl_dly_q    <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      lvl_q        <= lvl_d;
      lvl_dly_q    <= lvl_q;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
    end
  end

  assign high_time = high_time_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign stuck_hi  = stuck_hi_q;
  assign stuck_lo  = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: an 8-bit PWM generator model drives pwm_in, results checked per scenario.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int CNT_W       = 8;
  localparam int PER_W       = CNT_W + 1;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 384;
  localparam int FILTER_LEN  = 3;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT        = SYNC_STAGES + 1 + FILTER_LEN - 1;
  localparam int LOW_DUTY   = FILTER_LEN;
  localparam int HIGH_DUTY  = 256 - FILTER_LEN;
`else
  localparam int LAT        = SYNC_STAGES + 1;
  localparam int LOW_DUTY   = 1;
  localparam int HIGH_DUTY  = 255;
`endif
  localparam int M_GEN = 0, M_LO = 1, M_HI = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             pwm_in;
  logic [PER_W-1:0] high_time;
  logic [PER_W-1:0] period;
  logic             valid;
  logic             stuck_hi;
  logic             stuck_lo;

  int nvec = 0, nerr = 0, cyc = 0;
  int gen_cnt = 0, duty = 64, mode = M_LO;
  bit glitch = 1'b0;
  int cur_duty = 0, prev_duty = 0;
  int in_rise_cyc = -1, in_fall_cyc = -1;

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_W(CNT_W), .PER_W(PER_W), .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT(TIMEOUT), .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .high_time(high_time), .period(period), .valid(valid),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );

  // One clock of generator stimulus; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic nxt;
    if (gen_cnt == 0) begin
      prev_duty = cur_duty;
      cur_duty  = duty;
    end
    if (mode == M_LO)      nxt = 1'b0;
    else if (mode == M_HI) nxt = 1'b1;
    else nxt = (gen_cnt < duty) && !(glitch && (gen_cnt == 20 || gen_cnt == 21));
    if (nxt && !pwm_in) in_rise_cyc = cyc + 1;
    if (!nxt && pwm_in) in_fall_cyc = cyc + 1;
    pwm_in  = nxt;
    gen_cnt = (gen_cnt + 1) % 256;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (high_time !== '0) begin nerr++; $display("FAIL reset_high_time: got %0d want 0", high_time); end
    nvec++; if (period !== '0) begin nerr++; $display("FAIL reset_period: got %0d want 0", period); end
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", valid); end
    nvec++; if (stuck_hi !== 1'b0) begin nerr++; $display("FAIL reset_stuck_hi: got %b want 0", stuck_hi); end
    nvec++; if (stuck_lo !== 1'b0) begin nerr++; $display("FAIL reset_stuck_lo: got %b want 0", stuck_lo); end
    reset = 1'b0;
  endtask

  task automatic test_duty64();
    int r, first, nv;
    enable = 1'b1; mode = M_LO;
    repeat (4) tick();
    while (gen_cnt != 0) tick();
    mode = M_GEN; duty = 64;
    r = -1; first = -1; nv = 0;
    for (int i = 0; i < 780; i++) begin
      tick();
      if (i == 0) r = in_rise_cyc;
      if (valid) begin
        nv++;
        if (first < 0) first = cyc;
        nvec++; if (int'(high_time) != 64) begin nerr++; $display("FAIL d64_high_time: got %0d want 64", high_time); end
        nvec++; if (int'(period) != 256) begin nerr++; $display("FAIL d64_period: got %0d want 256", period); end
      end
    end
    nvec++; if (first != r + 256 + LAT) begin nerr++; $display("FAIL d64_first_valid_cycle: got %0d want %0d", first, r + 256 + LAT); end
    nvec++; if (nv != 3) begin nerr++; $display("FAIL d64_valid_count: got %0d want 3", nv); end
  endtask

  task automatic test_duty_extremes();
    int nv, nstk;
    nv = 0; nstk = 0;
    while (gen_cnt != 0) tick();
    for (int p = 0; p < 2; p++) begin
      duty = (p == 0) ? LOW_DUTY : HIGH_DUTY;
      for (int i = 0; i < 768; i++) begin
        tick();
        if (stuck_hi || stuck_lo) nstk++;
        if (valid) begin
          nv++;
          nvec++; if (int'(high_time) != prev_duty) begin nerr++; $display("FAIL ext_high_time: got %0d want %0d", high_time, prev_duty); end
          nvec++; if (int'(period) != 256) begin nerr++; $display("FAIL ext_period: got %0d want 256", period); end
        end
      end
    end
    nvec++; if (nv != 6) begin nerr++; $display("FAIL ext_valid_count: got %0d want 6", nv); end
    nvec++; if (nstk != 0) begin nerr++; $display("FAIL ext_no_stuck: got %0d stuck cycles want 0", nstk); end
  endtask

  task automatic test_stuck_lo();
    int stk, nv, r, clr, first, fht, fper;
    stk = -1; nv = 0;
    mode = M_LO;
    for (int i = 0; i < 600 && stk < 0; i++) begin
      tick();
      if (valid) nv++;
      if (stuck_lo) stk = cyc;
    end
    nvec++; if (stk != in_fall_cyc + LAT + TIMEOUT) begin nerr++; $display("FAIL slo_assert_cycle: got %0d want %0d", stk, in_fall_cyc + LAT + TIMEOUT); end
    nvec++; if (nv != 0) begin nerr++; $display("FAIL slo_no_valid: got %0d valids want 0", nv); end
    nvec++; if (stuck_hi !== 1'b0) begin nerr++; $display("FAIL slo_stuck_hi: got %b want 0", stuck_hi); end
    nvec++; if (int'(high_time) != HIGH_DUTY) begin nerr++; $display("FAIL slo_hold_high_time: got %0d want %0d", high_time, HIGH_DUTY); end
    nvec++; if (int'(period) != 256) begin nerr++; $display("FAIL slo_hold_period: got %0d want 256", period); end
    repeat (20) tick();
    while (gen_cnt != 0) tick();
    mode = M_GEN; duty = 64;
    r = -1; clr = -1; first = -1; fht = -1; fper = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) r = in_rise_cyc;
      if (!stuck_lo && clr < 0) clr = cyc;
      if (valid && first < 0) begin first = cyc; fht = int'(high_time); fper = int'(period); end
    end
    nvec++; if (clr != r + LAT) begin nerr++; $display("FAIL slo_clear_cycle: got %0d want %0d", clr, r + LAT); end
    nvec++; if (first != r + 256 + LAT) begin nerr++; $display("FAIL slo_next_valid_cycle: got %0d want %0d", first, r + 256 + LAT); end
    nvec++; if (fht != 64 || fper != 256) begin nerr++; $display("FAIL slo_next_result: got %0d/%0d want 64/256", fht, fper); end
  endtask

  task automatic test_stuck_hi();
    int stk, nv, r, f, clr;
    while (gen_cnt != 64) tick();
    mode = M_HI;
    r = in_rise_cyc; stk = -1; nv = 0;
    for (int i = 0; i < 500 && stk < 0; i++) begin
      tick();
      if (valid) nv++;
      if (stuck_hi) stk = cyc;
    end
    nvec++; if (stk != r + LAT + TIMEOUT) begin nerr++; $display("FAIL shi_assert_cycle: got %0d want %0d", stk, r + LAT + TIMEOUT); end
    nvec++; if (nv != 0) begin nerr++; $display("FAIL shi_no_valid: got %0d valids want 0", nv); end
    nvec++; if (stuck_lo !== 1'b0) begin nerr++; $display("FAIL shi_stuck_lo: got %b want 0", stuck_lo); end
    mode = M_LO;
    f = -1; clr = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) f = in_fall_cyc;
      if (!stuck_hi && clr < 0) clr = cyc;
    end
    nvec++; if (clr != f + LAT) begin nerr++; $display("FAIL shi_clear_cycle: got %0d want %0d", clr, f + LAT); end
    nvec++; if (int'(high_time) != 64 || int'(period) != 256) begin nerr++; $display("FAIL shi_hold: got %0d/%0d want 64/256", high_time, period); end
  endtask

  task automatic test_reset_mid();
    int nv, r, first, fht, fper;
    while (gen_cnt != 0) tick();
    mode = M_GEN; duty = 64;
    repeat (300) tick();
    while (gen_cnt != 100) tick();
    reset = 1'b1;
    #1;
    nvec++; if (high_time !== '0 || period !== '0) begin nerr++; $display("FAIL rmid_results: got %0d/%0d want 0/0", high_time, period); end
    nvec++; if (valid !== 1'b0 || stuck_hi !== 1'b0 || stuck_lo !== 1'b0) begin nerr++; $display("FAIL rmid_flags: got v%b h%b l%b want 000", valid, stuck_hi, stuck_lo); end
    nv = 0;
    repeat (3) begin tick(); if (valid) nv++; end
    reset = 1'b0;
    while (gen_cnt != 0) begin tick(); if (valid) nv++; end
    r = -1; first = -1; fht = -1; fper = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) r = in_rise_cyc;
      if (valid && first < 0) begin first = cyc; fht = int'(high_time); fper = int'(period); end
    end
    nvec++; if (nv != 0) begin nerr++; $display("FAIL rmid_no_valid: got %0d valids want 0", nv); end
    nvec++; if (first != r + 256 + LAT) begin nerr++; $display("FAIL rmid_restart_cycle: got %0d want %0d", first, r + 256 + LAT); end
    nvec++; if (fht != 64 || fper != 256) begin nerr++; $display("FAIL rmid_restart_result: got %0d/%0d want 64/256", fht, fper); end
  endtask

  task automatic test_enable();
    int nv, nstk, r, first, fht, fper;
    while (gen_cnt != 100) tick();
    enable = 1'b0; duty = 32;
    nv = 0; nstk = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (valid) nv++;
      if (stuck_hi || stuck_lo) nstk++;
    end
    nvec++; if (nv != 0) begin nerr++; $display("FAIL en_no_valid: got %0d valids want 0", nv); end
    nvec++; if (int'(high_time) != 64 || int'(period) != 256) begin nerr++; $display("FAIL en_hold: got %0d/%0d want 64/256", high_time, period); end
    nvec++; if (nstk != 0) begin nerr++; $display("FAIL en_no_stuck: got %0d stuck cycles want 0", nstk); end
    while (gen_cnt != 100) tick();
    enable = 1'b1;
    nv = 0;
    while (gen_cnt != 0) begin tick(); if (valid) nv++; end
    r = -1; first = -1; fht = -1; fper = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) r = in_rise_cyc;
      if (valid && first < 0) begin first = cyc; fht = int'(high_time); fper = int'(period); end
    end
    nvec++; if (nv != 0) begin nerr++; $display("FAIL en_arm_no_valid: got %0d valids want 0", nv); end
    nvec++; if (first != r + 256 + LAT) begin nerr++; $display("FAIL en_restart_cycle: got %0d want %0d", first, r + 256 + LAT); end
    nvec++; if (fht != 32 || fper != 256) begin nerr++; $display("FAIL en_restart_result: got %0d/%0d want 32/256", fht, fper); end
  endtask

  task automatic test_glitch();
    int nv, n_exp;
    int exp_ht [4];
    int exp_per[4];
`ifdef PWM_CAPTURE_FILTER_EN
    n_exp = 2;
    exp_ht  = '{64, 64, 0, 0};
    exp_per = '{256, 256, 0, 0};
`else
    n_exp = 4;
    exp_ht  = '{42, 20, 42, 20};
    exp_per = '{234, 22, 234, 22};
`endif
    duty = 64; glitch = 1'b1;
    while (gen_cnt != 0) tick();
    repeat (256) tick();
    nv = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (valid) begin
        if (nv < n_exp) begin
          nvec++; if (int'(high_time) != exp_ht[nv]) begin nerr++; $display("FAIL glitch_high_time[%0d]: got %0d want %0d", nv, high_time, exp_ht[nv]); end
          nvec++; if (int'(period) != exp_per[nv]) begin nerr++; $display("FAIL glitch_period[%0d]: got %0d want %0d", nv, period, exp_per[nv]); end
        end
        nv++;
      end
    end
    nvec++; if (nv != n_exp) begin nerr++; $display("FAIL glitch_valid_count: got %0d want %0d", nv, n_exp); end
    glitch = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_duty64();
    test_duty_extremes();
    test_stuck_lo();
    test_stuck_hi();
    test_reset_mid();
    test_enable();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
